// File: rtl/control_sequencer.sv
// Hardwired control unit: shared three-step fetch, then opcode-dependent execute steps T3-T7
// that drive every datapath enable, bus select and ALU opcode.
module control_sequencer #(
  parameter logic [4:0] ALU_ADD = 5'b00011,
  parameter logic [4:0] ALU_SUB = 5'b00100,
  parameter logic [4:0] ALU_AND = 5'b00101,
  parameter logic [4:0] ALU_OR  = 5'b00110
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] IR_Data,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        r_enable,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        ba_select,
  output logic        r_select,
  output logic        c_select,
  output logic        PC_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic [4:0]  alu_instruction,
  output logic [3:0]  state,
  output logic        instr_done,
  output logic        illegal_op,
  output logic        halted
);

  typedef enum logic [3:0] {
    StT0   = 4'd0,
    StT1   = 4'd1,
    StT2   = 4'd2,
    StT3   = 4'd3,
    StT4   = 4'd4,
    StT5   = 4'd5,
    StT6   = 4'd6,
    StT7   = 4'd7,
    StHalt = 4'd8
  } state_e;

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpAndi = 5'b01101;
  localparam logic [4:0] OpOri  = 5'b01110;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  state_e     state_q;
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = IR_Data[31:27];
  assign unused_ir = ^IR_Data[26:0];
  assign state     = state_q;

  // Instruction classes
  logic is_ld, is_ldi, is_st, is_reg_alu, is_imm_alu, is_nop, is_halt;
  logic is_mem, is_long;
  logic [4:0] imm_alu_code;

  always_comb begin
    is_ld        = 1'b0;
    is_ldi       = 1'b0;
    is_st        = 1'b0;
    is_reg_alu   = 1'b0;
    is_imm_alu   = 1'b0;
    is_nop       = 1'b0;
    is_halt      = 1'b0;
    imm_alu_code = ALU_ADD;
    case (opcode)
      OpLd:   is_ld = 1'b1;
      OpLdi:  is_ldi = 1'b1;
      OpSt:   is_st = 1'b1;
      OpAdd, OpSub, OpAnd, OpOr: is_reg_alu = 1'b1;
      OpAddi: is_imm_alu = 1'b1;
      OpAndi: begin
        is_imm_alu   = 1'b1;
        imm_alu_code = ALU_AND;
      end
      OpOri: begin
        is_imm_alu   = 1'b1;
        imm_alu_code = ALU_OR;
      end
      OpNop:  is_nop = 1'b1;
      OpHalt: is_halt = 1'b1;
      default: ;
    endcase
  end

  assign is_mem  = is_ld | is_ldi | is_st;
  assign is_long = is_ld | is_st;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StT0;
    end else begin
      unique case (state_q)
        StT0: state_q <= enable ? StT1 : StT0;
        StT1: state_q <= StT2;
        StT2: state_q <= StT3;
        StT3: begin
          if (is_mem || is_reg_alu || is_imm_alu) state_q <= StT4;
          else if (is_halt)                       state_q <= StHalt;
          else                                    state_q <= StT0;
        end
        StT4: state_q <= StT5;
        StT5: state_q <= is_long ? StT6 : StT0;
        StT6: state_q <= StT7;
        StT7: state_q <= StT0;
        StHalt: state_q <= StHalt;
        default: state_q <= StT0;
      endcase
    end
  end

  always_comb begin
    PC_enable           = 1'b0;
    PC_increment_enable = 1'b0;
    IR_enable           = 1'b0;
    Y_enable            = 1'b0;
    Z_enable            = 1'b0;
    MAR_enable          = 1'b0;
    MDR_enable          = 1'b0;
    r_enable            = 1'b0;
    read                = 1'b0;
    write               = 1'b0;
    Gra                 = 1'b0;
    Grb                 = 1'b0;
    Grc                 = 1'b0;
    ba_select           = 1'b0;
    r_select            = 1'b0;
    c_select            = 1'b0;
    PC_select           = 1'b0;
    Z_LO_select         = 1'b0;
    MDR_select          = 1'b0;
    alu_instruction     = 5'd0;
    instr_done          = 1'b0;
    illegal_op          = 1'b0;
    halted              = 1'b0;
    unique case (state_q)
      StT0: begin
        // Fetch starts only when enabled and not being reset this cycle
        if (enable && !reset) begin
          PC_select  = 1'b1;
          MAR_enable = 1'b1;
        end
      end
      StT1: begin
        PC_increment_enable = 1'b1;
        read                = 1'b1;
        MDR_enable          = 1'b1;
      end
      StT2: begin
        MDR_select = 1'b1;
        IR_enable  = 1'b1;
      end
      StT3: begin
        if (is_mem) begin
          Grb       = 1'b1;
          ba_select = 1'b1;
          Y_enable  = 1'b1;
        end else if (is_reg_alu) begin
          Grb      = 1'b1;
          r_select = 1'b1;
          Y_enable = 1'b1;
        end else if (is_imm_alu) begin
          c_select = 1'b1;
          Y_enable = 1'b1;
        end else begin
          instr_done = 1'b1;
          illegal_op = !(is_nop || is_halt);
        end
      end
      StT4: begin
        Z_enable = 1'b1;
        if (is_mem) begin
          c_select        = 1'b1;
          alu_instruction = ALU_ADD;
        end else if (is_reg_alu) begin
          Grc             = 1'b1;
          r_select        = 1'b1;
          alu_instruction = opcode;
        end else begin
          Grb             = 1'b1;
          r_select        = 1'b1;
          alu_instruction = imm_alu_code;
        end
      end
      StT5: begin
        Z_LO_select = 1'b1;
        if (is_long) begin
          MAR_enable = 1'b1;
        end else begin
          Gra        = 1'b1;
          r_enable   = 1'b1;
          instr_done = 1'b1;
        end
      end
      StT6: begin
        MDR_enable = 1'b1;
        if (is_st) begin
          Gra      = 1'b1;
          r_select = 1'b1;
        end else begin
          read = 1'b1;
        end
      end
      StT7: begin
        instr_done = 1'b1;
        if (is_st) begin
          write = 1'b1;
        end else begin
          MDR_select = 1'b1;
          Gra        = 1'b1;
          r_enable   = 1'b1;
        end
      end
      StHalt: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: each instruction is expanded into its expected per-step control list
// from the instruction table and compared cycle by cycle against the sequencer.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] IR_Data;
  logic PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable;
  logic r_enable, read, write, Gra, Grb, Grc, ba_select, r_select, c_select, PC_select;
  logic Z_LO_select, MDR_select, instr_done, illegal_op, halted;
  logic [4:0] alu_instruction;
  logic [3:0] state;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .IR_Data             (IR_Data),
    .PC_enable           (PC_enable),
    .PC_increment_enable (PC_increment_enable),
    .IR_enable           (IR_enable),
    .Y_enable            (Y_enable),
    .Z_enable            (Z_enable),
    .MAR_enable          (MAR_enable),
    .MDR_enable          (MDR_enable),
    .r_enable            (r_enable),
    .read                (read),
    .write               (write),
    .Gra                 (Gra),
    .Grb                 (Grb),
    .Grc                 (Grc),
    .ba_select           (ba_select),
    .r_select            (r_select),
    .c_select            (c_select),
    .PC_select           (PC_select),
    .Z_LO_select         (Z_LO_select),
    .MDR_select          (MDR_select),
    .alu_instruction     (alu_instruction),
    .state               (state),
    .instr_done          (instr_done),
    .illegal_op          (illegal_op),
    .halted              (halted)
  );

  logic [21:0] act_c;
  assign act_c = {PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable,
                  MDR_enable, r_enable, read, write, Gra, Grb, Grc, ba_select, r_select,
                  c_select, PC_select, Z_LO_select, MDR_select, instr_done, illegal_op, halted};

  localparam logic [21:0] M_PCINC  = 22'(1) << 20;
  localparam logic [21:0] M_IREN   = 22'(1) << 19;
  localparam logic [21:0] M_YEN    = 22'(1) << 18;
  localparam logic [21:0] M_ZEN    = 22'(1) << 17;
  localparam logic [21:0] M_MAREN  = 22'(1) << 16;
  localparam logic [21:0] M_MDREN  = 22'(1) << 15;
  localparam logic [21:0] M_REN    = 22'(1) << 14;
  localparam logic [21:0] M_READ   = 22'(1) << 13;
  localparam logic [21:0] M_WRITE  = 22'(1) << 12;
  localparam logic [21:0] M_GRA    = 22'(1) << 11;
  localparam logic [21:0] M_GRB    = 22'(1) << 10;
  localparam logic [21:0] M_GRC    = 22'(1) << 9;
  localparam logic [21:0] M_BA     = 22'(1) << 8;
  localparam logic [21:0] M_RSEL   = 22'(1) << 7;
  localparam logic [21:0] M_CSEL   = 22'(1) << 6;
  localparam logic [21:0] M_PCSEL  = 22'(1) << 5;
  localparam logic [21:0] M_ZLO    = 22'(1) << 4;
  localparam logic [21:0] M_MDRSEL = 22'(1) << 3;
  localparam logic [21:0] M_DONE   = 22'(1) << 2;
  localparam logic [21:0] M_ILL    = 22'(1) << 1;
  localparam logic [21:0] M_HALTED = 22'(1);

  typedef struct {
    logic [3:0]  st;
    logic [21:0] c;
    logic [4:0]  alu;
  } step_t;

  step_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic push(input logic [3:0] st, input logic [21:0] c, input logic [4:0] alu);
    step_t s;
    s.st  = st;
    s.c   = c;
    s.alu = alu;
    exp_q.push_back(s);
  endtask

  // Instruction table: expected controls for every step of one instruction.
  task automatic model_instr(input logic [4:0] op);
    exp_q.delete();
    push(4'd0, M_PCSEL | M_MAREN, 5'd0);
    push(4'd1, M_PCINC | M_READ | M_MDREN, 5'd0);
    push(4'd2, M_MDRSEL | M_IREN, 5'd0);
    case (op)
      5'b00000, 5'b00001, 5'b00010: begin
        push(4'd3, M_GRB | M_BA | M_YEN, 5'd0);
        push(4'd4, M_CSEL | M_ZEN, 5'b00011);
        if (op == 5'b00001) begin
          push(4'd5, M_ZLO | M_GRA | M_REN | M_DONE, 5'd0);
        end else begin
          push(4'd5, M_ZLO | M_MAREN, 5'd0);
          if (op == 5'b00000) begin
            push(4'd6, M_READ | M_MDREN, 5'd0);
            push(4'd7, M_MDRSEL | M_GRA | M_REN | M_DONE, 5'd0);
          end else begin
            push(4'd6, M_GRA | M_RSEL | M_MDREN, 5'd0);
            push(4'd7, M_WRITE | M_DONE, 5'd0);
          end
        end
      end
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        push(4'd3, M_GRB | M_RSEL | M_YEN, 5'd0);
        push(4'd4, M_GRC | M_RSEL | M_ZEN, op);
        push(4'd5, M_ZLO | M_GRA | M_REN | M_DONE, 5'd0);
      end
      5'b01100, 5'b01101, 5'b01110: begin
        push(4'd3, M_CSEL | M_YEN, 5'd0);
        push(4'd4, M_GRB | M_RSEL | M_ZEN,
             (op == 5'b01100) ? 5'b00011 : (op == 5'b01101) ? 5'b00101 : 5'b00110);
        push(4'd5, M_ZLO | M_GRA | M_REN | M_DONE, 5'd0);
      end
      5'b11010, 5'b11011: push(4'd3, M_DONE, 5'd0);
      default:            push(4'd3, M_DONE | M_ILL, 5'd0);
    endcase
  endtask

  // Runs up to max_steps steps of one instruction with enable held high, checking each step.
  task automatic run_instr(input string name, input logic [31:0] ir, input int max_steps);
    model_instr(ir[31:27]);
    IR_Data = ir;
    enable  = 1'b1;
    for (int i = 0; i < exp_q.size() && i < max_steps; i++) begin
      @(negedge clk);
      total++;
      if (state !== exp_q[i].st || act_c !== exp_q[i].c || alu_instruction !== exp_q[i].alu) begin
        bad++;
        $display("FAIL %s step%0d: got state=%0d ctrl=%h alu=%h, want state=%0d ctrl=%h alu=%h",
                 name, i, state, act_c, alu_instruction, exp_q[i].st, exp_q[i].c, exp_q[i].alu);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    enable  = 1'b1;
    IR_Data = 32'h0900_0065;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (state !== 4'd0 || act_c !== 22'd0 || alu_instruction !== 5'd0) begin
        bad++;
        $display("FAIL reset: got state=%0d ctrl=%h alu=%h, want 0/0/0",
                 state, act_c, alu_instruction);
      end
      @(posedge clk);
      #1;
    end
    reset  = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_enable_hold;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (state !== 4'd0 || act_c !== 22'd0 || alu_instruction !== 5'd0) begin
        bad++;
        $display("FAIL idle%0d: got state=%0d ctrl=%h alu=%h, want 0/0/0",
                 i, state, act_c, alu_instruction);
      end
      @(posedge clk);
      #1;
    end
    run_instr("ldi", 32'h0900_0065, 99);
  endtask

  task automatic test_directed;
    run_instr("ori", 32'h7190_0053, 99);
    run_instr("st", 32'h1088_0010, 99);
    run_instr("sub", 32'h2119_8000, 99);
    run_instr("nop", 32'hD000_0000, 99);
    run_instr("illegal", 32'hF800_0000, 99);
    run_instr("ld", 32'h0080_0004, 99);
  endtask

  task automatic test_random;
    logic [4:0] op;
    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'b11011) op = 5'b11010;
      run_instr("random", {op, 27'($urandom)}, 99);
      if ($urandom_range(0, 3) == 0) begin
        enable = 1'b0;
        @(negedge clk);
        total++;
        if (state !== 4'd0 || act_c !== 22'd0) begin
          bad++;
          $display("FAIL gap: got state=%0d ctrl=%h, want 0/0", state, act_c);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset_mid;
    // Stop inside ld's T6, then reset
    run_instr("ld_abort", 32'h0100_0020, 6);
    @(negedge clk);
    total++;
    if (state !== 4'd6) begin
      bad++;
      $display("FAIL ld_abort_t6: got state=%0d, want 6", state);
    end
    reset  = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (state !== 4'd0 || act_c !== 22'd0 || alu_instruction !== 5'd0) begin
      bad++;
      $display("FAIL reset_mid: got state=%0d ctrl=%h alu=%h, want 0/0/0",
               state, act_c, alu_instruction);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_halt;
    run_instr("halt", 32'hD800_0000, 99);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (state !== 4'd8 || act_c !== M_HALTED || alu_instruction !== 5'd0) begin
        bad++;
        $display("FAIL halted%0d: got state=%0d ctrl=%h alu=%h, want 8/%h/0",
                 i, state, act_c, alu_instruction, M_HALTED);
      end
      @(posedge clk);
      #1;
    end
    reset  = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (state !== 4'd0 || halted !== 1'b0 || act_c !== 22'd0) begin
      bad++;
      $display("FAIL halt_reset: got state=%0d halted=%b ctrl=%h, want 0/0/0",
               state, halted, act_c);
    end
    @(posedge clk);
    #1;
    run_instr("after_halt", 32'h6110_0007, 99);
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    IR_Data = 32'd0;
    test_reset();
    test_enable_hold();
    test_directed();
    test_random();
    test_reset_mid();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
